// File: rtl/lenet_pkg.sv
// Shared LeNet FP16 datapath definitions: element width, S4 pooled-map geometry
// and the state type of the pool-to-F5 flatten streamer.
package lenet_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int S4_DEPTH   = 16;
    localparam int S4_H       = 5;
    localparam int S4_W       = 5;
    localparam int F5_IN      = S4_DEPTH * S4_H * S4_W;

    typedef logic [15:0] fp16_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } flat_state_t;

endpackage

// File: rtl/pool_flatten_streamer_if.sv
// Handshake bundle of the flatten streamer: wide parallel map capture on the
// input side, valid/ready FP16 element stream plus done pulse on the output side.
interface pool_flatten_streamer_if #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int N          = lenet_pkg::F5_IN
);
    localparam int CW = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [CW-1:0]           out_index;
    logic                    out_last;
    logic                    done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, done
    );

endinterface

// File: rtl/flatten_addr_gen.sv
// Beat counter and buffer read-address generator for the flatten streamer.
// next_index is the buffer element that the beat after the current one reads.
module flatten_addr_gen #(
    parameter int ORDER = 0,
    parameter int DEPTH = 16,
    parameter int H     = 5,
    parameter int W     = 5,
    parameter int N     = DEPTH * H * W,
    parameter int CW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] next_index,
    output logic [CW-1:0] out_index,
    output logic          is_last
);
    localparam int HW = H * W;

    logic [CW-1:0] beat_r, addr_r, d_r, w_r, h_r, col_r, row_r;
    logic [CW-1:0] beat_s, addr_s, d_s, w_s, h_s, col_s, row_s;

    // Next counter values; in HWC order the address steps a whole plane per
    // channel and rewinds to the next pixel (col) when the channel count wraps.
    always_comb begin
        beat_s = beat_r + CW'(1);
        addr_s = beat_s;
        d_s    = d_r;
        w_s    = w_r;
        h_s    = h_r;
        col_s  = col_r;
        row_s  = row_r;
        if (beat_r == CW'(N - 1)) begin
            beat_s = '0;
            addr_s = '0;
            d_s    = '0;
            w_s    = '0;
            h_s    = '0;
            col_s  = '0;
            row_s  = '0;
        end else if (ORDER == 1) begin
            if (d_r == CW'(DEPTH - 1)) begin
                d_s = '0;
                if (w_r == CW'(W - 1)) begin
                    w_s   = '0;
                    h_s   = h_r + CW'(1);
                    row_s = row_r + CW'(W);
                    col_s = row_s;
                end else begin
                    w_s   = w_r + CW'(1);
                    col_s = col_r + CW'(1);
                end
                addr_s = col_s;
            end else begin
                d_s    = d_r + CW'(1);
                addr_s = addr_r + CW'(HW);
            end
        end else begin
            addr_s = beat_s;
        end
    end

    // Counter registers: cleared on capture, stepped on each accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_r <= '0;
            addr_r <= '0;
            d_r    <= '0;
            w_r    <= '0;
            h_r    <= '0;
            col_r  <= '0;
            row_r  <= '0;
        end else if (clear) begin
            beat_r <= '0;
            addr_r <= '0;
            d_r    <= '0;
            w_r    <= '0;
            h_r    <= '0;
            col_r  <= '0;
            row_r  <= '0;
        end else if (advance) begin
            beat_r <= beat_s;
            addr_r <= addr_s;
            d_r    <= d_s;
            w_r    <= w_s;
            h_r    <= h_s;
            col_r  <= col_s;
            row_r  <= row_s;
        end else begin
            beat_r <= beat_r;
            addr_r <= addr_r;
            d_r    <= d_r;
            w_r    <= w_r;
            h_r    <= h_r;
            col_r  <= col_r;
            row_r  <= row_r;
        end
    end

    assign next_index = addr_s;
    assign out_index  = beat_r;
    assign is_last    = (beat_r == CW'(N - 1));

endmodule

// File: rtl/pool_flatten_streamer.sv
// Captures the S4 pooled map in one cycle and streams it to F5 as FP16 words
// (CHW or HWC order), flagging the last beat and pulsing done afterwards.
module pool_flatten_streamer #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int Depth      = lenet_pkg::S4_DEPTH,
    parameter int outH       = lenet_pkg::S4_H,
    parameter int outW       = lenet_pkg::S4_W,
    parameter int ORDER      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    pool_flatten_streamer_if.slave  bus
);
    import lenet_pkg::*;

    localparam int N  = Depth * outH * outW;
    localparam int CW = $clog2(N);

    flat_state_t           state_r;
    logic [DATA_WIDTH-1:0] buf_r [N];
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic                  done_r;
    logic                  capture_s;
    logic                  accept_s;
    logic [CW-1:0]         next_index_s;
    logic [CW-1:0]         out_index_s;
    logic                  is_last_s;

    assign capture_s = (state_r == IDLE) && bus.in_valid;
    assign accept_s  = (state_r == STREAM) && bus.out_ready;

    flatten_addr_gen #(
        .ORDER (ORDER),
        .DEPTH (Depth),
        .H     (outH),
        .W     (outW),
        .N     (N),
        .CW    (CW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (capture_s),
        .advance    (accept_s),
        .next_index (next_index_s),
        .out_index  (out_index_s),
        .is_last    (is_last_s)
    );

    // Capture/stream FSM; out_data is preloaded so each beat is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            buf_r[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        out_data_r  <= bus.in_data[DATA_WIDTH-1:0];
                        out_valid_r <= 1'b1;
                        out_last_r  <= (N == 1) ? 1'b1 : 1'b0;
                        state_r     <= STREAM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (is_last_s) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= IDLE;
                        end else begin
                            out_data_r <= buf_r[next_index_s];
                            out_last_r <= (out_index_s == CW'(N - 2));
                        end
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_index = out_index_s;
    assign bus.out_last  = out_last_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_pool_flatten_streamer.sv
// Directed bench for pool_flatten_streamer: CHW streaming, back-to-back maps,
// backpressure, ignored in_valid, mid-stream reset, and HWC ordering.
module tb_pool_flatten_streamer;

    localparam int DW = 16;
    localparam int N  = 400;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [N*DW-1:0] map_a;
    logic [N*DW-1:0] map_b;

    pool_flatten_streamer_if #(.DATA_WIDTH(DW), .N(N)) if0 ();
    pool_flatten_streamer_if #(.DATA_WIDTH(DW), .N(N)) if1 ();

    pool_flatten_streamer #(.ORDER(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    pool_flatten_streamer #(.ORDER(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic capture0(input logic [N*DW-1:0] m);
        if0.in_data  = m;
        if0.in_valid = 1'b1;
        check("cap_in_ready", {31'd0, if0.in_ready}, 32'd1);
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    // Streams one map from dut0 at negedges; stall/inject/abort at given beats (-1 = never).
    task automatic run_stream(input logic [15:0] base, input int stall_at,
                              input int inject_at, input int abort_at);
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_valid", {31'd0, if0.out_valid}, 32'd0);
                check("abort_done", {31'd0, if0.done}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (k == stall_at) begin
                if0.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_data", {16'd0, if0.out_data}, {16'd0, base + k[15:0]});
                    check("stall_index", {23'd0, if0.out_index}, k);
                    check("stall_valid", {31'd0, if0.out_valid}, 32'd1);
                    @(negedge clk);
                end
                if0.out_ready = 1'b1;
            end
            check("beat_valid", {31'd0, if0.out_valid}, 32'd1);
            check("beat_data", {16'd0, if0.out_data}, {16'd0, base + k[15:0]});
            check("beat_index", {23'd0, if0.out_index}, k);
            check("beat_last", {31'd0, if0.out_last}, (k == N - 1) ? 32'd1 : 32'd0);
            if (k == inject_at) begin
                if0.in_data  = map_b;
                if0.in_valid = 1'b1;
                check("inject_in_ready", {31'd0, if0.in_ready}, 32'd0);
            end
            @(negedge clk);
            if0.in_valid = 1'b0;
        end
        check("end_done", {31'd0, if0.done}, 32'd1);
        check("end_valid", {31'd0, if0.out_valid}, 32'd0);
        check("end_in_ready", {31'd0, if0.in_ready}, 32'd1);
        check("end_index", {23'd0, if0.out_index}, 32'd0);
    endtask

    initial begin
        int d;
        int p;
        clk = 1'b0;
        reset = 1'b1;
        n_checks = 0;
        n_pass = 0;
        for (int i = 0; i < N; i++) begin
            map_a[i*DW +: DW] = 16'h3C00 + 16'(i);
            map_b[i*DW +: DW] = 16'h5000 + 16'(i);
        end
        if0.in_valid = 1'b0;
        if0.in_data = '0;
        if0.out_ready = 1'b1;
        if1.in_valid = 1'b0;
        if1.in_data = '0;
        if1.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
        check("rst_valid", {31'd0, if0.out_valid}, 32'd0);
        check("rst_last", {31'd0, if0.out_last}, 32'd0);
        check("rst_done", {31'd0, if0.done}, 32'd0);
        check("rst_data", {16'd0, if0.out_data}, 32'd0);
        check("rst_index", {23'd0, if0.out_index}, 32'd0);
        reset = 1'b0;

        // T1: full CHW stream
        capture0(map_a);
        run_stream(16'h3C00, -1, -1, -1);

        // T6: second map in the cycle done is high
        capture0(map_b);
        run_stream(16'h5000, -1, -1, -1);
        @(negedge clk);
        check("done_pulse_width", {31'd0, if0.done}, 32'd0);

        // T3 + T4: stall at beat 10, foreign in_valid at beat 50
        capture0(map_a);
        run_stream(16'h3C00, 10, 50, -1);

        // T5: reset at beat 200, then a fresh map from beat 0
        capture0(map_a);
        run_stream(16'h3C00, -1, -1, 200);
        check("post_rst_index", {23'd0, if0.out_index}, 32'd0);
        check("post_rst_done", {31'd0, if0.done}, 32'd0);
        check("post_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
        capture0(map_a);
        run_stream(16'h3C00, -1, -1, -1);

        // T2: HWC order on dut1
        if1.in_data = map_a;
        if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            d = k % 16;
            p = k / 16;
            check("hwc_data", {16'd0, if1.out_data}, {16'd0, 16'h3C00 + 16'(d * 25 + p)});
            check("hwc_last", {31'd0, if1.out_last}, (k == N - 1) ? 32'd1 : 32'd0);
            if (k == 0)   check("hwc_beat0", {16'd0, if1.out_data}, 32'h3C00);
            if (k == 1)   check("hwc_beat1", {16'd0, if1.out_data}, 32'h3C19);
            if (k == 16)  check("hwc_beat16", {16'd0, if1.out_data}, 32'h3C01);
            if (k == 399) check("hwc_beat399", {16'd0, if1.out_data}, 32'h3D8F);
            @(negedge clk);
        end
        check("hwc_done", {31'd0, if1.done}, 32'd1);
        check("hwc_valid_end", {31'd0, if1.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
